// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the Flappy Bird game controller.
//  - state_t      : FSM state encoding, also the encoding driven on the state port
//  - BCD_W        : width of a 3-digit packed BCD score
//  - *_FRAMES_DEF : default dwell times (in frames) for DYING and OVER
//  - bcd_max      : larger of two packed BCD values
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DYING = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int BCD_W = 12;

  localparam int unsigned DIE_FRAMES_DEF  = 32;
  localparam int unsigned OVER_FRAMES_DEF = 60;

  // Packed BCD with every digit in 0..9 orders the same way as plain binary,
  // so an unsigned compare is a valid magnitude compare.
  function automatic logic [BCD_W-1:0] bcd_max(input logic [BCD_W-1:0] a,
                                               input logic [BCD_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_sequencer_bcd.sv
// bcd_counter3: 3-digit packed BCD incrementer {hund,tens,ones}.
// Ports:
//  clk    in   clock
//  rst_n  in   asynchronous active-low reset (count -> 000)
//  clr    in   synchronous clear, wins over inc
//  inc    in   add one with decimal carry; saturates at 999
//  count  out  current BCD value
module bcd_counter3
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] count
);

  logic [BCD_W-1:0] count_next;
  logic [2:0]       carry;

  // No increment at all once the value is 999, so it sticks there.
  assign carry[0] = inc & (count != 12'h999);

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig = count[4*gi +: 4];
    assign count_next[4*gi +: 4] = carry[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
    if (gi < 2) begin : g_carry
      assign carry[gi+1] = carry[gi] & (dig == 4'd9);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level Flappy Bird controller.
//  Derives a per-frame tick from vsync, turns spacebar presses into
//  frame-aligned flap pulses, runs the IDLE/PLAY/DYING/OVER FSM and keeps
//  the BCD score and best score.
// Ports:
//  clk          in   board clock
//  rst_n        in   asynchronous active-low reset (released synchronously inside)
//  vs           in   vsync, active-low pulse
//  btn          in   spacebar level, asynchronous
//  collide      in   collision level, sampled on frame ticks in PLAY
//  pipe_passed  in   1-clk pulse, scores a point while in PLAY
//  frame_tick   out  1-clk pulse per vs falling edge
//  run_en       out  datapath may advance on frame_tick
//  flap         out  bird impulse, coincident with frame_tick
//  clear        out  reload start positions, coincident with frame_tick
//  state        out  00 IDLE, 01 PLAY, 10 DYING, 11 OVER
//  score        out  3-digit BCD score
//  hi_score     out  3-digit BCD best score since reset
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned DIE_FRAMES  = DIE_FRAMES_DEF,
  parameter int unsigned OVER_FRAMES = OVER_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             btn,
  input  logic             collide,
  input  logic             pipe_passed,
  output logic             frame_tick,
  output logic             run_en,
  output logic             flap,
  output logic             clear,
  output logic [1:0]       state,
  output logic [BCD_W-1:0] score,
  output logic [BCD_W-1:0] hi_score
);

  localparam logic [7:0] DIE_LIM  = DIE_FRAMES[7:0];
  localparam logic [7:0] OVER_LIM = OVER_FRAMES[7:0];

  // Reset: asserts immediately, releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int_n = rst_pipe[1];

  // Input synchronisation and edge detection. vs registers reset high (vs idle
  // level) so leaving reset never fakes a falling edge.
  logic btn_s1, btn_s2, btn_prev;
  logic vs_s, vs_prev;
  logic press, fall;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
      vs_s     <= 1'b1;
      vs_prev  <= 1'b1;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      vs_s     <= vs;
      vs_prev  <= vs_s;
    end
  end

  assign press = btn_s2 & ~btn_prev;
  assign fall  = vs_prev & ~vs_s;

  // The FSM decides on the cycle the vs fall is detected; its registered
  // outputs then appear in the same cycle as the registered frame_tick.
  state_t     state_reg;
  logic       press_latch;
  logic       press_event;
  logic [7:0] frame_cnt;
  logic [7:0] cnt_inc;
  logic       score_clr, score_inc;

  assign press_event = press_latch | press;
  assign cnt_inc     = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
  assign score_clr   = fall & (state_reg == ST_IDLE) & press_event;
  assign score_inc   = pipe_passed & (state_reg == ST_PLAY);
  assign state       = state_reg;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg   <= ST_IDLE;
      press_latch <= 1'b0;
      frame_cnt   <= 8'd0;
      frame_tick  <= 1'b0;
      run_en      <= 1'b0;
      flap        <= 1'b0;
      clear       <= 1'b0;
      hi_score    <= '0;
    end else begin
      frame_tick <= fall;
      flap       <= 1'b0;
      clear      <= 1'b0;

      // Every tick consumes the pending press, whether or not the state uses it.
      if (fall)       press_latch <= 1'b0;
      else if (press) press_latch <= 1'b1;

      if (fall) begin
        case (state_reg)
          ST_IDLE: begin
            if (press_event) begin
              state_reg <= ST_PLAY;
              run_en    <= 1'b1;
              clear     <= 1'b1;
              flap      <= 1'b1;
            end
          end
          ST_PLAY: begin
            // Collision wins: no flap on the tick that kills the bird.
            if (collide) begin
              state_reg <= ST_DYING;
              run_en    <= 1'b0;
              frame_cnt <= 8'd0;
            end else begin
              flap <= press_event;
            end
          end
          ST_DYING: begin
            if (cnt_inc >= DIE_LIM) begin
              state_reg <= ST_OVER;
              frame_cnt <= 8'd0;
              hi_score  <= bcd_max(hi_score, score);
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
          ST_OVER: begin
            if ((frame_cnt >= OVER_LIM) && press_event) begin
              state_reg <= ST_IDLE;
              clear     <= 1'b1;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            run_en    <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_counter3 u_score (
    .clk   (clk),
    .rst_n (rst_int_n),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (score)
  );

endmodule
